// File: rtl/stacktrbuf_pkg.sv
// rtl/stacktrbuf_pkg.sv - shared constants and register layout for the call-stack trace buffer
package stacktrbuf_pkg;

    localparam int RISCV_ARCH      = 64;
    localparam int CFG_STKTR_ABITS = 5;
    localparam int CFG_STKTR_XLEN  = RISCV_ARCH;

    typedef struct packed {
        logic [CFG_STKTR_ABITS-1:0]  wptr;
        logic [CFG_STKTR_ABITS:0]    count;
        logic                        overflow;
        logic                        underflow;
        logic [2*CFG_STKTR_XLEN-1:0] rdata;
    } stacktrbuf_registers;

endpackage

// File: rtl/stacktrbuf_ram.sv
// rtl/stacktrbuf_ram.sv - simple dual-port frame RAM, synchronous write, registered read-old port
module stacktrbuf_ram
    import stacktrbuf_pkg::*;
#(
    parameter int abits = CFG_STKTR_ABITS,
    parameter int dbits = 2 * CFG_STKTR_XLEN
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [abits-1:0] i_waddr,
    input  logic [dbits-1:0] i_wdata,
    input  logic [abits-1:0] i_raddr,
    output logic [dbits-1:0] o_rdata
);

    logic [dbits-1:0] mem [2**abits];
    logic [dbits-1:0] rdata_q;

    // Read and write share one edge; the read samples the pre-write contents.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        rdata_q <= mem[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/stacktrbuf_lifo.sv
// rtl/stacktrbuf_lifo.sv - circular LIFO of {pc, npc} call frames with top-relative debug read
module stacktrbuf_lifo
    import stacktrbuf_pkg::*;
#(
    parameter int abits = CFG_STKTR_ABITS,
    parameter int xlen  = CFG_STKTR_XLEN
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [xlen-1:0]   i_pc,
    input  logic [xlen-1:0]   i_npc,
    input  logic              i_clear,
    input  logic [abits-1:0]  i_raddr,
    output logic [2*xlen-1:0] o_rdata,
    output logic [abits:0]    o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int               DEPTH = 2**abits;
    localparam logic [abits:0]   FULL  = (abits+1)'(DEPTH);
    localparam logic [abits-1:0] ONE   = 1;

    logic [abits-1:0]  wptr_q, wptr_d;
    logic [abits:0]    count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rvalid_q, rvalid_d;

    logic              ram_we;
    logic [abits-1:0]  ram_waddr;
    logic [abits-1:0]  ram_raddr;
    logic [2*xlen-1:0] ram_rdata;

    always_comb begin
        wptr_d      = wptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        ram_we      = 1'b0;
        ram_waddr   = wptr_q;
        ram_raddr   = wptr_q - ONE - i_raddr;
        rvalid_d    = ({1'b0, i_raddr} < count_q);

        if (i_clear) begin
            wptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (i_push && i_pop && (count_q != '0)) begin
            // Tail call: replace the top frame in place.
            ram_we    = 1'b1;
            ram_waddr = wptr_q - ONE;
        end else if (i_push) begin
            ram_we = 1'b1;
            wptr_d = wptr_q + ONE;
            if (count_q != FULL) begin
                count_d = count_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (i_pop) begin
            if (count_q != '0) begin
                wptr_d  = wptr_q - ONE;
                count_d = count_q - 1'b1;
            end else begin
                underflow_d = 1'b1;
            end
        end

        if (i_rst) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rvalid_q    <= rvalid_d;
        end
    end

    stacktrbuf_ram #(
        .abits (abits),
        .dbits (2 * xlen)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (ram_waddr),
        .i_wdata ({i_pc, i_npc}),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    // Out-of-range reads are masked to zero in step with the RAM read.
    assign o_rdata     = rvalid_q ? ram_rdata : '0;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: doc/stacktrbuf_lifo.md
# stacktrbuf_lifo

Parametrised hardware call-stack trace buffer for the River core. It captures `{pc, npc}` pairs on call instructions and discards them on returns, keeping a circular LIFO of the most recent call frames. When full, the oldest frame is overwritten and an overflow is flagged. It sits beside the executor and is read by the debug module through a registered, top-relative read port.

## Interface
Parameters:
- `abits`, 5: address width; depth `DEPTH = 2**abits`.
- `xlen`, 64: width of pc/npc; an entry is `2*xlen` bits.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_push`  in  1  call retired (jal/jalr with link register): store a frame.
- `i_pop`  in  1  return retired: discard the top frame.
- `i_pc`  in  xlen  pc of the calling instruction.
- `i_npc`  in  xlen  call target.
- `i_clear`  in  1  flush the buffer (debug command).
- `i_raddr`  in  abits  debug read index; 0 is the most recent frame.
- `o_rdata`  out  2*xlen  `{pc, npc}` of the selected frame, registered.
- `o_count`  out  abits+1  number of valid frames, range 0..DEPTH.
- `o_overflow`  out  1  sticky; set when a push overwrote the oldest frame.
- `o_underflow`  out  1  sticky; set when a pop arrived while empty.

## Operation
- State:
  - `wptr[abits-1:0]`: next free slot.
  - `count[abits:0]`.
  - The two sticky flags.
  - `mem[DEPTH]` of `2*xlen`-bit entries.
- Event priority per cycle: `i_rst` > `i_clear` > push/pop.
- `i_clear`: `wptr=0`, `count=0`, both flags cleared. `mem` is untouched. Any push/pop in the same cycle is ignored.
- Push only:
  - `mem[wptr] = {i_pc, i_npc}`; `wptr = wptr+1` mod DEPTH.
  - If `count<DEPTH`: `count+1`.
  - Else: `count` stays at DEPTH and `o_overflow` is set (oldest frame lost).
- Pop only:
  - If `count>0`: `wptr = wptr-1` mod DEPTH; `count-1`.
  - Else: no pointer or count change; `o_underflow` is set.
- Push and pop together (tail call, e.g. jalr with rd=ra, rs1≠ra):
  - If `count>0`: `mem[wptr-1]` is overwritten with the new frame; `wptr` and `count` are unchanged.
  - If `count==0`: treat as a plain push; `o_underflow` is not set.
- Read index is `idx = (wptr - 1 - i_raddr)` mod DEPTH, using the pre-edge `wptr`.
  - If `i_raddr < count`: `o_rdata <= mem[idx]`.
  - Otherwise `o_rdata <= 0`.
  - Read-old semantics: a same-cycle write is not observed.
- Pointer arithmetic is unsigned and modulo DEPTH. `count` never exceeds DEPTH and never wraps below 0.
- The sticky flags clear only on `i_rst` or `i_clear`.

## Timing
- Reset values (synchronous, effective at the first edge with `i_rst=1`):
  - `o_rdata=0`, `o_count=0`, `o_overflow=0`, `o_underflow=0`, `wptr=0`.
  - `mem` is not reset.
- Reset mid-operation discards all frames and any push/pop in that cycle.
- `o_count` and the flags are registered: they update at the edge that samples the event.
- Read latency is 1 cycle: `i_raddr` presented in cycle N gives `o_rdata` valid in cycle N+1.
- A push sampled at edge E is visible to a read issued in the cycle after E, with data appearing at edge E+1.
- No handshake or backpressure; one push/pop event per cycle is accepted unconditionally.

## Structure
- Shared package `stacktrbuf_pkg` holds:
  - Default constants `CFG_STKTR_ABITS=5`, `CFG_STKTR_XLEN=RISCV_ARCH`.
  - The registers struct typedef with `wptr`, `count`, `overflow`, `underflow`, `rdata`, sized from those defaults.
- Sub-module `stacktrbuf_ram`: simple dual-port RAM of `DEPTH x 2*xlen`, one synchronous write port and one registered read port, no reset. The top holds the pointer/count logic and the `raddr<count` zero-masking; the masking is registered alongside the RAM read.
- Expected size is roughly 200 lines of RTL.

## Test plan
- **Reset, then read:** assert `i_rst` 1 cycle, then read `i_raddr=0` → `o_count=0`, `o_rdata=0`, both flags 0.
- **Three pushes, then reads:** push (0x100,0x200), (0x110,0x300), (0x120,0x400), then read `i_raddr`=0,1,2,3 → `o_rdata` = {0x120,0x400}, {0x110,0x300}, {0x100,0x200}, 0 (one cycle each); `o_count=3`.
- **Overflow:** with `abits=2`, push 5 frames (pc=1..5) → `o_count=4`, `o_overflow=1`, `i_raddr=3` returns pc=2. Then pop 4 times plus 1 more → `o_count=0`, `o_underflow=1`.
- **Tail call:** after 2 pushes, push+pop in the same cycle with pc=0x900 → `o_count=2`, `i_raddr=0` returns pc=0x900, `i_raddr=1` returns the first frame. Push+pop while empty → `o_count=1`, `o_underflow=0`.
- **Clear priority:** `i_clear` with `i_push` in the same cycle while `count=2`, `overflow=1` → `o_count=0`, flags 0, and the next read returns 0.
- **Wrap-around and read-old:** run 40 push/pop cycles crossing the `wptr` wrap with `abits=5` and compare against a reference model. A read of `i_raddr=0` in the same cycle as a push returns the previous top.
